// File: rtl/online_mul_datapath.sv
// rtl/online_mul_datapath.sv - radix-2 online (MSD-first) signed-digit multiplier datapath
//
// Purpose: consumes one x digit and one y digit per enabled step and produces
// one product digit per step after DELTA warm-up steps. The outer handshake
// belongs to the multiplier top level.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           begin a new product (ignored while busy)
//   en              step enable, en=0 stalls every register
//   x_dig, y_dig    operand digits: 2'b10=+1, 2'b01=-1, 2'b00/2'b11=0
//   busy            product in progress
//   p_dig, p_vd     registered product digit and its valid flag
//   done            one-cycle pulse alongside the last product digit
//
// Optional build macro ONLINE_MUL_DBG_EN adds:
//   dbg_w           current residual W
//   dbg_bad         sticky flag: a 2'b11 digit was sampled (cleared by rst/start)

module online_mul_datapath #(
    parameter int NDIG  = 8,
    parameter int DELTA = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  en,
    input  logic [1:0]            x_dig,
    input  logic [1:0]            y_dig,
    output logic                  busy,
    output logic [1:0]            p_dig,
    output logic                  p_vd,
    output logic                  done
`ifdef ONLINE_MUL_DBG_EN
    ,
    output logic [NDIG+DELTA+2:0] dbg_w,
    output logic                  dbg_bad
`endif
);

    // Residual: 3 integer bits (incl. sign) + NDIG+DELTA fractional bits.
    localparam int FW = NDIG + DELTA;
    localparam int WW = FW + 3;
    // Operands: sign bit + NDIG fractional bits (|X|,|Y| < 1).
    localparam int OW = NDIG + 1;
    // Selector sum SX+SY may reach magnitude < 2: one extra integer bit.
    localparam int SW = OW + 1;
    localparam int KW = $clog2(NDIG + DELTA + 1);

    localparam logic [KW-1:0] K_NDIG  = KW'(NDIG);
    localparam logic [KW-1:0] K_DELTA = KW'(DELTA);
    localparam logic [KW-1:0] K_LAST  = KW'(NDIG + DELTA);
    localparam logic [WW-1:0] ONE_W   = {3'b001, {FW{1'b0}}};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t state, state_next;

    logic [KW-1:0] k;
    logic [OW-1:0] x_reg, y_reg;
    logic [WW-1:0] w_reg;

    logic          in_digits, warm;
    logic [KW-1:0] sh;
    logic [OW-1:0] ulp;
    logic          xp, xn, yp, yn;
    logic [OW-1:0] x_inc, y_inc, x_new, y_new;
    logic [OW-1:0] sx, sy;
    logic [SW-1:0] sel_sum;
    logic [WW-1:0] v, w_next;
    logic signed [3:0] vh;
    logic          p_pos, p_neg;
    logic [1:0]    p_code;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start)                state_next = S_RUN;
            S_RUN:  if (en && (k == K_LAST))  state_next = S_IDLE;
            default:                          state_next = S_IDLE;
        endcase
    end

    assign busy = (state == S_RUN);

    // ------------------------------------------------------------------
    // Step datapath
    // ------------------------------------------------------------------
    always_comb begin
        in_digits = (k <= K_NDIG);
        warm      = (k <= K_DELTA);
        // Weight 2^-k in operand LSB units; sh is only meaningful while digits are consumed.
        sh        = K_NDIG - k;
        ulp       = in_digits ? (OW'(1) << sh) : '0;

        xp = in_digits && (x_dig == 2'b10);
        xn = in_digits && (x_dig == 2'b01);
        yp = in_digits && (y_dig == 2'b10);
        yn = in_digits && (y_dig == 2'b01);

        x_inc = xp ? ulp : (xn ? -ulp : '0);
        y_inc = yp ? ulp : (yn ? -ulp : '0);
        x_new = x_reg + x_inc;
        y_new = y_reg + y_inc;

        // SX uses the updated Y, SY the not-yet-updated X.
        sx = xp ? y_new : (xn ? -y_new : '0);
        sy = yp ? x_reg : (yn ? -x_reg : '0);
        sel_sum = {sx[OW-1], sx} + {sy[OW-1], sy};

        // The 2^-DELTA scaling is free: an NDIG-fraction value sits at the
        // bottom of the NDIG+DELTA-fraction residual already shifted by DELTA.
        v  = {w_reg[WW-2:0], 1'b0} + {{(WW-SW){sel_sum[SW-1]}}, sel_sum};
        // Top 4 bits = V truncated toward -inf to half-unit resolution.
        vh = v[WW-1:WW-4];

        p_pos = !warm && (vh >= 4'sd1);
        p_neg = !warm && (vh <= -4'sd2);

        w_next = p_pos ? (v - ONE_W) : (p_neg ? (v + ONE_W) : v);
        p_code = p_pos ? 2'b10 : (p_neg ? 2'b01 : 2'b00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k     <= '0;
            x_reg <= '0;
            y_reg <= '0;
            w_reg <= '0;
            p_dig <= 2'b00;
            p_vd  <= 1'b0;
            done  <= 1'b0;
        end else begin
            p_vd <= 1'b0;
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (start) begin
                    k     <= KW'(1);
                    x_reg <= '0;
                    y_reg <= '0;
                    w_reg <= '0;
                end
            end else if (en) begin
                x_reg <= x_new;
                y_reg <= y_new;
                w_reg <= w_next;
                p_dig <= p_code;
                p_vd  <= !warm;
                done  <= (k == K_LAST);
                if (k != K_LAST) begin
                    k <= k + KW'(1);
                end
            end
        end
    end

`ifdef ONLINE_MUL_DBG_EN
    assign dbg_w = w_reg;

    always_ff @(posedge clk) begin
        if (rst || ((state == S_IDLE) && start)) begin
            dbg_bad <= 1'b0;
        end else if (busy && en && in_digits && ((x_dig == 2'b11) || (y_dig == 2'b11))) begin
            dbg_bad <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_online_mul_datapath.sv
// tb/tb_online_mul_datapath.sv - self-checking bench for online_mul_datapath
//
// Purpose: drives directed and random digit streams and checks the emitted
// product digits against the arithmetic value X*Y, plus timing of p_vd/done,
// stall, start-while-busy and mid-product reset behaviour.
// Ports: none (top-level bench).

module tb_online_mul_datapath;

    logic       clk = 1'b0;
    logic       rst, start, en;
    logic [1:0] x_dig, y_dig;
    logic       busy, p_vd, done;
    logic [1:0] p_dig;
`ifdef ONLINE_MUL_DBG_EN
    logic [13:0] dbg_w;
    logic        dbg_bad;
`endif

    online_mul_datapath #(.NDIG(8), .DELTA(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .en    (en),
        .x_dig (x_dig),
        .y_dig (y_dig),
        .busy  (busy),
        .p_dig (p_dig),
        .p_vd  (p_vd),
        .done  (done)
`ifdef ONLINE_MUL_DBG_EN
        ,
        .dbg_w   (dbg_w),
        .dbg_bad (dbg_bad)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] xs [1:8];
    logic [1:0] ys [1:8];
    int gd     [0:15];
    int gd_ref [0:15];
    int nval, first_cyc, last_cyc, done_cyc, pval;
    int busy_at_done, bad_code;

    function automatic int dec(input logic [1:0] d);
        return (d == 2'b10) ? 1 : ((d == 2'b01) ? -1 : 0);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One product: start, then feed digit k on the k-th enabled step.
    // Outputs are sampled on the falling edge, inputs driven there too.
    task automatic run(input int stall_at, input int stall_len, input int poke_cyc, input int rst_at);
        int kk;
        bit stalled;
        nval = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; pval = 0;
        busy_at_done = -1; bad_code = 0;
        for (int i = 0; i < 16; i++) gd[i] = 99;
        kk = 1;
        @(negedge clk);
        start = 1'b1; en = 1'b1; x_dig = 2'b00; y_dig = 2'b00;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            if (p_vd) begin
                if (nval < 16) gd[nval] = dec(p_dig);
                if (p_dig == 2'b11) bad_code = 1;
                nval++;
                if (nval <= 8) pval += dec(p_dig) * (1 << (8 - nval));
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (done) begin
                done_cyc     = cyc;
                busy_at_done = int'(busy);
            end
            if (rst_at > 0 && cyc == rst_at + 1) begin
                check("rst_mid/busy",  int'(busy),  0);
                check("rst_mid/p_vd",  int'(p_vd),  0);
                check("rst_mid/p_dig", int'(p_dig), 0);
                rst = 1'b0;
                return;
            end
            stalled = (cyc >= stall_at) && (cyc < stall_at + stall_len);
            en    = !stalled;
            rst   = (cyc == rst_at);
            start = (cyc == poke_cyc);
            x_dig = (kk <= 8) ? xs[kk] : 2'b00;
            y_dig = (kk <= 8) ? ys[kk] : 2'b00;
            if (!stalled) kk++;
            @(negedge clk);
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    // Value-level model: X*Y from the digit lists, in units of 2^-16.
    task automatic check_product(input string tag, input int exp_first, input int exp_last);
        int xv, yv, xy, err, ok;
        xv = 0; yv = 0;
        for (int i = 1; i <= 8; i++) begin
            xv += dec(xs[i]) * (1 << (8 - i));
            yv += dec(ys[i]) * (1 << (8 - i));
        end
        xy  = xv * yv;
        err = pval * 256 - xy;
        ok  = ((xy % 256) == 0) ? int'(err == 0) : int'(err > -256 && err < 256);
        check({tag, "/nval"},     nval,         8);
        check({tag, "/first"},    first_cyc,    exp_first);
        check({tag, "/last"},     last_cyc,     exp_last);
        check({tag, "/done"},     done_cyc,     exp_last);
        check({tag, "/busy_end"}, busy_at_done, 0);
        check({tag, "/code11"},   bad_code,     0);
        check({tag, "/accuracy"}, ok,           1);
    endtask

    task automatic set_ops(input int xf, input int yf);
        for (int i = 1; i <= 8; i++) begin
            xs[i] = 2'b00;
            ys[i] = 2'b00;
        end
        xs[1] = xf[1:0];
        ys[1] = yf[1:0];
    endtask

    task automatic set_random();
        for (int i = 1; i <= 8; i++) begin
            xs[i] = 2'($urandom_range(0, 3));
            ys[i] = 2'($urandom_range(0, 3));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; en = 1'b0; x_dig = 2'b00; y_dig = 2'b00;
        repeat (2) @(negedge clk);
        check("reset/busy",  int'(busy),  0);
        check("reset/p_vd",  int'(p_vd),  0);
        check("reset/p_dig", int'(p_dig), 0);
        check("reset/done",  int'(done),  0);
        rst = 1'b0;
        @(negedge clk);

        // All-zero operands: eight valid zero digits.
        set_ops(0, 0);
        run(0, 0, 0, 0);
        check_product("zero", 5, 12);
        for (int i = 0; i < 8; i++) check($sformatf("zero/dig%0d", i + 1), gd[i], 0);

        // 0.5 * 0.5
        set_ops(2, 2);
        run(0, 0, 0, 0);
        check_product("half_sq", 5, 12);
        check("half_sq/value", pval, 64);

        // 0.5 * -0.5
        set_ops(2, 1);
        run(0, 0, 0, 0);
        check_product("half_neg", 5, 12);
        check("half_neg/value", pval, -64);

        // (1-2^-8)^2
        for (int i = 1; i <= 8; i++) begin
            xs[i] = 2'b10;
            ys[i] = 2'b10;
        end
        run(0, 0, 0, 0);
        check_product("all_ones", 5, 12);

        // Random operands (2'b11 digits included, valued 0).
        for (int t = 0; t < 8; t++) begin
            set_random();
            run(0, 0, 0, 0);
            check_product($sformatf("rand%0d", t), 5, 12);
        end

        // Stall: same digits, valid window moves 3 cycles later.
        set_random();
        run(0, 0, 0, 0);
        check_product("stall_ref", 5, 12);
        for (int i = 0; i < 16; i++) gd_ref[i] = gd[i];
        run(3, 3, 0, 0);
        check_product("stall", 8, 15);
        for (int i = 0; i < 8; i++) check($sformatf("stall/dig%0d", i + 1), gd[i], gd_ref[i]);

        // start pulsed while busy has no effect.
        run(0, 0, 6, 0);
        check_product("poke", 5, 12);
        for (int i = 0; i < 8; i++) check($sformatf("poke/dig%0d", i + 1), gd[i], gd_ref[i]);

        // Reset at step 5, then a clean 0.25 product.
        set_ops(2, 2);
        run(0, 0, 0, 5);
        run(0, 0, 0, 0);
        check_product("after_rst", 5, 12);
        check("after_rst/value", pval, 64);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
